// File: rtl/tx_frame_ctrl_ble.sv
// Transmit frame sequencer: serializes bus/DMA words LSB-first into a header burst,
// a one-cycle idle gap and a payload burst, with TX-complete interrupt and DMA request.
module tx_frame_ctrl_ble #(
  parameter int DATA = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     header_size,
  input  logic [15:0]     payload_size,
  input  logic [DATA-1:0] word_in,
  input  logic            word_valid,
  output logic            word_ready,
  output logic            bit_out,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            header_sel,
  output logic            payload_sel,
  output logic            tx_busy,
  output logic            tx_done,
  output logic            underrun_err,
  input  logic            tx_irq_en,
  input  logic            tx_irq_clear,
  output logic            tx_irq,
  output logic            chain_clr_tx_irq,
  input  logic            dma_mode,
  input  logic            dma_ack,
  input  logic            tx_dma_done,
  output logic            tx_dma_req,
  output logic [2:0]      state_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HEADER  = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int CW = $clog2(DATA + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA);

  // Handshakes: a word moves on word_valid & word_ready, a bit moves on
  // bit_valid & bit_ready; valid sides hold their data until accepted.
  logic [2:0]      state;
  logic [15:0]     rem;
  logic [15:0]     pay_q;
  logic [DATA-1:0] sr;
  logic [CW-1:0]   sr_cnt;
  logic            underrun_q;
  logic            irq_flag;
  logic            ack_reg;
  logic            req_flag;
  logic            chain_q;

  logic in_sec;
  logic consume;
  logic load;
  logic need_more;
  logic last_bit;
  logic start_acc;

  always_comb begin
    in_sec     = (state == HEADER) || (state == PAYLOAD);
    bit_valid  = in_sec && (sr_cnt != '0);
    consume    = bit_valid && bit_ready;
    need_more  = rem > 16'(sr_cnt);
    // Refill either from empty or in the same cycle the last buffered bit leaves.
    word_ready = in_sec && need_more &&
                 ((sr_cnt == '0) || ((sr_cnt == CW'(1)) && consume));
    load       = word_ready && word_valid;
    last_bit   = consume && (rem == 16'd1);
    start_acc  = (state == IDLE) && start;
  end

  assign bit_out          = sr[0];
  assign header_sel       = (state == HEADER) && bit_valid;
  assign payload_sel      = (state == PAYLOAD) && bit_valid;
  assign tx_busy          = state != IDLE;
  assign tx_done          = state == DONE;
  assign underrun_err     = underrun_q;
  assign tx_irq           = irq_flag && tx_irq_en;
  assign chain_clr_tx_irq = chain_q;
  assign tx_dma_req       = dma_mode && req_flag;
  assign state_dbg        = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rem        <= '0;
      pay_q      <= '0;
      sr         <= '0;
      sr_cnt     <= '0;
      underrun_q <= 1'b0;
      irq_flag   <= 1'b0;
      ack_reg    <= 1'b0;
      req_flag   <= 1'b0;
      chain_q    <= 1'b0;
    end else begin
      chain_q <= tx_irq_clear;

      if (tx_dma_done)  ack_reg <= 1'b0;
      else if (dma_ack) ack_reg <= 1'b1;

      if (ack_reg)        req_flag <= 1'b0;
      else if (start_acc) req_flag <= 1'b1;

      if (tx_irq_clear) irq_flag <= 1'b0;
      else if (tx_done) irq_flag <= 1'b1;

      if (load) begin
        sr     <= word_in;
        sr_cnt <= FULL;
      end else if (consume) begin
        sr     <= {1'b0, sr[DATA-1:1]};
        sr_cnt <= sr_cnt - CW'(1);
      end

      if (in_sec && (sr_cnt == '0) && !load) underrun_q <= 1'b1;
      if (consume) rem <= rem - 16'd1;

      case (state)
        IDLE: begin
          if (start) begin
            pay_q      <= payload_size;
            underrun_q <= 1'b0;
            if (header_size != 16'd0) begin
              state <= HEADER;
              rem   <= header_size;
            end else if (payload_size != 16'd0) begin
              state <= PAYLOAD;
              rem   <= payload_size;
            end else begin
              state <= DONE;
            end
          end
        end
        HEADER: begin
          // Leftover high bits of the final header word are dropped here.
          if (last_bit) begin
            sr_cnt <= '0;
            state  <= (pay_q == 16'd0) ? DONE : GAP;
          end
        end
        GAP: begin
          state <= PAYLOAD;
          rem   <= pay_q;
        end
        PAYLOAD: begin
          if (last_bit) begin
            sr_cnt <= '0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl_ble.sv
// Bench for tx_frame_ctrl_ble: random and directed frames, expected bits queued per
// frame from the word list and popped by an independent monitor on each consumed bit.
module tb_tx_frame_ctrl_ble;
  localparam int DATA = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [15:0]     header_size;
  logic [15:0]     payload_size;
  logic [DATA-1:0] word_in;
  logic            word_valid;
  logic            word_ready;
  logic            bit_out;
  logic            bit_valid;
  logic            bit_ready;
  logic            header_sel;
  logic            payload_sel;
  logic            tx_busy;
  logic            tx_done;
  logic            underrun_err;
  logic            tx_irq_en;
  logic            tx_irq_clear;
  logic            tx_irq;
  logic            chain_clr_tx_irq;
  logic            dma_mode;
  logic            dma_ack;
  logic            tx_dma_done;
  logic            tx_dma_req;
  logic [2:0]      state_dbg;

  tx_frame_ctrl_ble #(.DATA(DATA)) dut (
    .clk(clk), .reset(reset), .start(start),
    .header_size(header_size), .payload_size(payload_size),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .header_sel(header_sel), .payload_sel(payload_sel),
    .tx_busy(tx_busy), .tx_done(tx_done), .underrun_err(underrun_err),
    .tx_irq_en(tx_irq_en), .tx_irq_clear(tx_irq_clear), .tx_irq(tx_irq),
    .chain_clr_tx_irq(chain_clr_tx_irq),
    .dma_mode(dma_mode), .dma_ack(dma_ack), .tx_dma_done(tx_dma_done),
    .tx_dma_req(tx_dma_req), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]      exp_q[$];   // {is_payload, bit}
  logic [DATA-1:0] hw[$];
  logic [DATA-1:0] pw[$];

  int   br_mode = 0;
  int   cur_p = 0;
  int   pay_cnt = 0;
  int   abort_pay = 0;
  bit   abort_now = 0;
  int   after_hdr = 0;
  int   after_pay = 0;
  int   done_cnt = 0;
  bit   clr_on_done = 0;
  bit   hold_pending = 0;
  logic hold_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bit_ready pattern: steady, alternating or random
  initial begin
    bit_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (br_mode)
        0:       bit_ready = 1'b1;
        1:       bit_ready = ~bit_ready;
        default: bit_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        after_hdr = 0;
        after_pay = 0;
        hold_pending = 0;
        continue;
      end
      if (tx_done) done_cnt++;
      if (after_hdr == 1) begin
        if (cur_p > 0) check("gap_slot", 32'({bit_valid, tx_busy, tx_done}), 32'b010);
        else           check("done_after_hdr", 32'(tx_done), 32'd1);
        after_hdr = 0;
      end
      if (after_pay == 2) begin
        check("idle_after_done", 32'({tx_busy, tx_done}), 32'd0);
        check("irq_after_done", 32'(tx_irq), 32'(tx_irq_en && !clr_on_done));
        if (clr_on_done) tx_irq_clear = 1'b0;
        after_pay = 0;
      end
      if (after_pay == 1) begin
        check("done_after_pay", 32'(tx_done), 32'd1);
        after_pay = 2;
      end
      if (hold_pending) begin
        check("hold_stable", 32'({bit_valid, bit_out}), 32'({1'b1, hold_bit}));
        hold_pending = 0;
      end
      if (bit_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          check("bit_sel", 32'({header_sel, payload_sel}), exp_q[0][1] ? 32'b01 : 32'b10);
          if (bit_ready) begin
            e = exp_q.pop_front();
            check("bit_val", 32'(bit_out), 32'(e[0]));
            if (e[1]) begin
              pay_cnt++;
              if (exp_q.size() == 0) begin
                after_pay = 1;
                if (clr_on_done) tx_irq_clear = 1'b1;
              end
              if (abort_pay > 0 && pay_cnt == abort_pay) begin
                reset = 1'b0;
                abort_now = 1;
              end
            end else if (exp_q.size() == 0 || exp_q[0][1]) begin
              after_hdr = 1;
            end
          end else begin
            hold_pending = 1;
            hold_bit = bit_out;
          end
        end
      end
    end
  end

  // driver: one frame from hw/pw; stall > 0 withholds word_valid after the first word
  task automatic run_frame(input int h, input int p, input int stall);
    logic [DATA-1:0] wq[$];
    logic [DATA-1:0] w;
    int nh, np, base, guard;
    bit ok;
    nh = (h + DATA - 1) / DATA;
    np = (p + DATA - 1) / DATA;
    for (int i = 0; i < h; i++) begin
      w = hw[i / DATA];
      exp_q.push_back({1'b0, w[i % DATA]});
    end
    for (int i = 0; i < p; i++) begin
      w = pw[i / DATA];
      exp_q.push_back({1'b1, w[i % DATA]});
    end
    for (int i = 0; i < nh; i++) wq.push_back(hw[i]);
    for (int i = 0; i < np; i++) wq.push_back(pw[i]);
    cur_p = p;
    pay_cnt = 0;
    base = done_cnt;

    @(posedge clk); #1;
    start = 1'b1;
    header_size = 16'(h);
    payload_size = 16'(p);
    word_valid = wq.size() > 0;
    word_in = (wq.size() > 0) ? wq[0] : '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_c1", 32'(tx_busy), 32'd1);
    check("underrun_clr_c1", 32'(underrun_err), 32'd0);
    check("dma_req_c1", 32'(tx_dma_req), 32'(dma_mode));
    check("word_ready_c1", 32'(word_ready), 32'(h > 0 || p > 0));

    for (int i = 0; i < wq.size(); i++) begin
      word_in = wq[i];
      word_valid = 1'b1;
      guard = 0;
      ok = 0;
      while (!ok && !abort_now && guard < 4000) begin
        @(negedge clk);
        ok = word_ready && word_valid && reset;
        @(posedge clk); #1;
        guard++;
      end
      if (abort_now) break;
      if (!ok) begin
        check("word_timeout", 32'd0, 32'd1);
        break;
      end
      if (i == 0 && stall > 0) begin
        word_valid = 1'b0;
        for (int c = 1; c <= stall; c++) begin
          if (c == stall - 2) begin
            check("stall_no_bit", 32'(bit_valid), 32'd0);
            check("underrun_set", 32'(underrun_err), 32'd1);
          end
          @(posedge clk); #1;
        end
      end
    end
    word_valid = 1'b0;

    guard = 0;
    while (!abort_now && (done_cnt == base || after_pay != 0 || after_hdr != 0) && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end

    if (abort_now) begin
      check("reset_outputs_mid", 32'({word_ready, bit_out, bit_valid, header_sel, payload_sel,
            tx_busy, tx_done, underrun_err, tx_irq, chain_clr_tx_irq, tx_dma_req}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("no_done_on_reset", 32'(done_cnt - base), 32'd0);
      exp_q.delete();
      reset = 1'b1;
      abort_now = 0;
      abort_pay = 0;
    end else begin
      if (guard >= 5000) check("frame_timeout", 32'd0, 32'd1);
      check("frame_done_once", 32'(done_cnt - base), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("underrun_final", 32'(underrun_err), 32'(stall > 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_random_words();
    hw.delete();
    pw.delete();
    for (int i = 0; i < 3; i++) begin
      hw.push_back(DATA'($urandom));
      pw.push_back(DATA'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    header_size = '0;
    payload_size = '0;
    word_in = '0;
    word_valid = 1'b0;
    tx_irq_en = 1'b0;
    tx_irq_clear = 1'b0;
    dma_mode = 1'b0;
    dma_ack = 1'b0;
    tx_dma_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({word_ready, bit_out, bit_valid, header_sel, payload_sel,
          tx_busy, tx_done, underrun_err, tx_irq, chain_clr_tx_irq, tx_dma_req}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // basic frame, then the same frame under alternating backpressure
    hw = {32'h0003_ABCD};
    pw = {32'hDEAD_BEEF, 32'h0000_00A5};
    run_frame(18, 40, 0);
    br_mode = 1;
    run_frame(18, 40, 0);
    br_mode = 0;

    // zero-size sections
    fill_random_words();
    run_frame(0, 40, 0);
    run_frame(18, 0, 0);
    run_frame(0, 0, 0);

    // underrun during a 64-bit header, then a clean frame clears it
    fill_random_words();
    run_frame(64, 20, DATA + 5);
    run_frame(10, 10, 0);

    // interrupt and DMA request
    tx_irq_en = 1'b1;
    dma_mode = 1'b1;
    fill_random_words();
    run_frame(5, 7, 0);
    check("irq_held", 32'(tx_irq), 32'd1);
    tx_irq_clear = 1'b1;
    @(posedge clk); #1;
    tx_irq_clear = 1'b0;
    check("chain_pulse", 32'(chain_clr_tx_irq), 32'd1);
    check("irq_cleared", 32'(tx_irq), 32'd0);
    @(posedge clk); #1;
    check("chain_pulse_end", 32'(chain_clr_tx_irq), 32'd0);
    check("dma_req_held", 32'(tx_dma_req), 32'd1);
    dma_ack = 1'b1;
    @(posedge clk); #1;
    dma_ack = 1'b0;
    @(posedge clk); #1;
    check("dma_req_drop", 32'(tx_dma_req), 32'd0);
    tx_dma_done = 1'b1;
    @(posedge clk); #1;
    tx_dma_done = 1'b0;
    clr_on_done = 1;
    run_frame(5, 7, 0);
    clr_on_done = 0;

    // reset after 10 payload bits, then a full frame
    fill_random_words();
    abort_pay = 10;
    run_frame(8, 40, 0);
    run_frame(8, 40, 0);

    // randomized frames under random backpressure
    br_mode = 2;
    for (int f = 0; f < 8; f++) begin
      int h, p;
      fill_random_words();
      h = int'($urandom_range(0, 90));
      p = int'($urandom_range(0, 90));
      run_frame(h, p, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
